// File: rtl/noc_params.sv
// Shared NoC parameters and types: flit layout, VC count/width and the
// per-VC transmit state used by output_port_tx.
package noc_params;
    localparam int VC_NUM         = 4;
    localparam int VC_SIZE        = $clog2(VC_NUM);
    localparam int FLIT_DATA_SIZE = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t                flit_label;
        logic [VC_SIZE-1:0]         vc_id;
        logic [FLIT_DATA_SIZE-1:0]  data;
    } flit_t;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } tx_vc_state_t;

    // A single-flit packet both opens and closes its VC.
    function automatic logic is_head(input flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

    function automatic logic is_tail(input flit_label_t label);
        return (label == TAIL) || (label == HEADTAIL);
    endfunction
endpackage

// File: rtl/tx_fifo.sv
// Transmit FIFO with first-word-fall-through head; pointers wrap naturally
// because FIFO_DEPTH is a power of two.
module tx_fifo
    import noc_params::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  flit_t din,
    output flit_t dout,
    output logic  full,
    output logic  empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    flit_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);
endmodule

// File: rtl/output_port_tx.sv
// Router output port: round-robin downstream VC allocation, transmit FIFO and
// on/off-gated output register. Define OUTPUT_PORT_TX_CHECK_EN for protocol checks.
module output_port_tx
    import noc_params::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  flit_t              data_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [VC_NUM-1:0]  on_off_i,
    input  logic               alloc_req_i,
    output logic               alloc_valid_o,
    output logic [VC_SIZE-1:0] alloc_vc_o,
    output flit_t              data_o,
    output logic               valid_o,
    output logic [VC_NUM-1:0]  vc_free_o,
    output logic               error_o
);
    logic [VC_SIZE-1:0] rr_ptr_reg, rr_ptr_next;
    logic [VC_SIZE-1:0] search_idx;
    logic               free_found;
    logic               out_valid_reg, out_valid_next;
    flit_t              out_data_reg, out_data_next;
    logic               load_out, accept, tail_sent;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    flit_t              fifo_dout;

    // Allocation only sees registered VC state, so a VC freed this cycle waits a cycle.
    always_comb begin
        free_found    = 1'b0;
        search_idx    = '0;
        alloc_vc_o    = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            search_idx = rr_ptr_reg + VC_SIZE'(i);
            if (!free_found && vc_free_o[search_idx]) begin
                free_found = 1'b1;
                alloc_vc_o = search_idx;
            end
        end
        alloc_valid_o = alloc_req_i && free_found;
        if (!alloc_valid_o) alloc_vc_o = '0;
        rr_ptr_next = alloc_valid_o ? alloc_vc_o + VC_SIZE'(1) : rr_ptr_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr_reg <= '0;
        else      rr_ptr_reg <= rr_ptr_next;
    end

    assign tail_sent = valid_o && is_tail(out_data_reg.flit_label);

    for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc
        tx_vc_state_t state_reg, state_next;

        always_comb begin
            state_next = state_reg;
            case (state_reg)
                FREE: if (alloc_valid_o && alloc_vc_o == VC_SIZE'(gi)) state_next = BUSY;
                BUSY: if (tail_sent && out_data_reg.vc_id == VC_SIZE'(gi)) state_next = FREE;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) state_reg <= FREE;
            else      state_reg <= state_next;
        end

        assign vc_free_o[gi] = (state_reg == FREE);
    end

    assign valid_o  = out_valid_reg && on_off_i[out_data_reg.vc_id];
    assign data_o   = out_data_reg;
    assign load_out = !out_valid_reg || valid_o;
    assign fifo_pop = load_out && !fifo_empty;
    assign ready_o  = !fifo_full || fifo_pop;
    assign accept   = valid_i && ready_o;
    // With nothing queued ahead, an accepted flit bypasses straight into the output register.
    assign fifo_push = accept && !(load_out && fifo_empty);

    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        if (load_out) begin
            if (!fifo_empty) begin
                out_valid_next = 1'b1;
                out_data_next  = fifo_dout;
            end else if (accept) begin
                out_valid_next = 1'b1;
                out_data_next  = data_i;
            end else begin
                out_valid_next = 1'b0;
                out_data_next  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
        end
    end

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef OUTPUT_PORT_TX_CHECK_EN
    logic [VC_NUM-1:0] open_reg, open_next;
    logic              error_reg, protocol_err;

    always_comb begin
        open_next    = open_reg;
        protocol_err = 1'b0;
        if (accept) begin
            if (vc_free_o[data_i.vc_id]) protocol_err = 1'b1;
            if (is_head(data_i.flit_label) && open_reg[data_i.vc_id]) protocol_err = 1'b1;
            if (is_head(data_i.flit_label)) open_next[data_i.vc_id] = 1'b1;
            if (is_tail(data_i.flit_label)) open_next[data_i.vc_id] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            open_reg  <= '0;
            error_reg <= 1'b0;
        end else begin
            open_reg  <= open_next;
            error_reg <= error_reg || protocol_err;
        end
    end

    assign error_o = error_reg;
`else
    assign error_o = 1'b0;
`endif
endmodule

// File: tb/tb_output_port_tx.sv
// Scoreboard bench for output_port_tx: directed scenarios plus random packets,
// checked by a negedge monitor against a queue/array reference model.
module tb_output_port_tx;
    import noc_params::*;

    logic               clk = 1'b0;
    logic               rst;
    flit_t              data_i;
    logic               valid_i;
    logic               ready_o;
    logic [VC_NUM-1:0]  on_off_i;
    logic               alloc_req_i;
    logic               alloc_valid_o;
    logic [VC_SIZE-1:0] alloc_vc_o;
    flit_t              data_o;
    logic               valid_o;
    logic [VC_NUM-1:0]  vc_free_o;
    logic               error_o;

    always #5 clk = ~clk;

    output_port_tx #(.FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .on_off_i      (on_off_i),
        .alloc_req_i   (alloc_req_i),
        .alloc_valid_o (alloc_valid_o),
        .alloc_vc_o    (alloc_vc_o),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .vc_free_o     (vc_free_o),
        .error_o       (error_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic flit_t mk(input flit_label_t label, input int vc);
        flit_t f;
        f.flit_label = label;
        f.vc_id      = VC_SIZE'(vc);
        f.data       = FLIT_DATA_SIZE'($urandom);
        return f;
    endfunction

    function automatic logic tb_tail(input flit_label_t l);
        return (l == TAIL) || (l == HEADTAIL);
    endfunction

    // Reference model: expected flit order, VC free map, round-robin pointer, sticky error.
    flit_t             exp_q[$];
    logic [VC_NUM-1:0] m_free;
    int                m_ptr;
    logic              m_err;
    logic [VC_NUM-1:0] m_open;
    logic              m_gok;
    int                m_g;
    flit_t             m_e;
    logic              m_tail;
    int                m_tail_vc;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_free = '1;
            m_ptr  = 0;
            m_err  = 1'b0;
            m_open = '0;
        end else begin
            m_gok = 1'b0;
            m_g   = 0;
            for (int i = 0; i < VC_NUM; i++) begin
                if (!m_gok && m_free[(m_ptr + i) % VC_NUM]) begin
                    m_gok = 1'b1;
                    m_g   = (m_ptr + i) % VC_NUM;
                end
            end
            chk("alloc_valid", alloc_valid_o, alloc_req_i && m_gok);
            chk("alloc_vc", alloc_vc_o, (alloc_req_i && m_gok) ? m_g : 0);
            chk("vc_free", vc_free_o, m_free);
            chk("error", error_o, m_err);

            m_tail = 1'b0;
            m_tail_vc = 0;
            if (valid_o) begin
                chk("tx_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    m_e = exp_q.pop_front();
                    chk("data_o", data_o, m_e);
                    $display("tx vc=%0d label=%0d data=%h", data_o.vc_id, data_o.flit_label, data_o.data);
                    if (tb_tail(m_e.flit_label)) begin
                        m_tail    = 1'b1;
                        m_tail_vc = m_e.vc_id;
                    end
                end
            end

            if (valid_i && ready_o) begin
`ifdef OUTPUT_PORT_TX_CHECK_EN
                if (m_free[data_i.vc_id]) m_err = 1'b1;
                if ((data_i.flit_label == HEAD || data_i.flit_label == HEADTAIL) && m_open[data_i.vc_id])
                    m_err = 1'b1;
                if (data_i.flit_label == HEAD || data_i.flit_label == HEADTAIL) m_open[data_i.vc_id] = 1'b1;
                if (tb_tail(data_i.flit_label)) m_open[data_i.vc_id] = 1'b0;
`endif
                exp_q.push_back(data_i);
            end

            if (m_tail) m_free[m_tail_vc] = 1'b1;
            if (alloc_req_i && m_gok) begin
                m_free[m_g] = 1'b0;
                m_ptr       = (m_g + 1) % VC_NUM;
            end
        end
    end

    task automatic send_flit(input flit_t f);
        logic ok;
        ok      = 1'b0;
        data_i  = f;
        valid_i = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            ok = ready_o;
            tick();
            on_off_i = 4'($urandom) | 4'($urandom);
            if (ok) break;
        end
        valid_i = 1'b0;
        chk("accept_in_time", ok, 1);
    endtask

    flit_t f3 [3];
    flit_t fh, fb, ft;
    logic  exp_err;
    logic  got;
    int    vc, len;

    initial begin
        rst         = 1'b0;
        valid_i     = 1'b0;
        data_i      = '0;
        on_off_i    = '1;
        alloc_req_i = 1'b0;
`ifdef OUTPUT_PORT_TX_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_vc_free", vc_free_o, 4'hf);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_alloc_valid", alloc_valid_o, 0);
        chk("rst_error", error_o, 0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", ready_o, 1);

        // Four grants in round-robin order, then none left
        tick();
        alloc_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s1_grant_valid", alloc_valid_o, 1);
            chk("s1_grant_vc", alloc_vc_o, i);
            tick();
        end
        @(negedge clk);
        chk("s1_no_grant", alloc_valid_o, 0);
        chk("s1_no_grant_vc", alloc_vc_o, 0);
        tick();
        alloc_req_i = 1'b0;

        // HEAD/BODY/TAIL on VC2, one-cycle latency each
        fh = mk(HEAD, 2); fb = mk(BODY, 2); ft = mk(TAIL, 2);
        data_i = fh; valid_i = 1'b1;
        @(negedge clk); chk("s2_ready", ready_o, 1);
        tick(); data_i = fb;
        @(negedge clk); chk("s2_valid_h", valid_o, 1); chk("s2_data_h", data_o, fh);
        tick(); data_i = ft;
        @(negedge clk); chk("s2_data_b", data_o, fb);
        tick(); valid_i = 1'b0;
        @(negedge clk); chk("s2_valid_t", valid_o, 1); chk("s2_data_t", data_o, ft);
        chk("s2_vc2_busy", vc_free_o[2], 0);
        tick();
        @(negedge clk); chk("s2_vc2_free", vc_free_o[2], 1);
        chk("s2_idle_valid", valid_o, 0); chk("s2_idle_data", data_o, 0);
        tick();

        // Back-pressure on VC1 fills the FIFO, then releases in order
        on_off_i = 4'b1101;
        f3[0] = mk(HEAD, 1); f3[1] = mk(BODY, 1); f3[2] = mk(TAIL, 1);
        for (int k = 0; k < 3; k++) begin
            data_i = f3[k]; valid_i = 1'b1;
            @(negedge clk); chk("s3_ready_fill", ready_o, 1);
            tick();
        end
        valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s3_ready_full", ready_o, 0);
            chk("s3_valid_stall", valid_o, 0);
            chk("s3_data_hold", data_o, f3[0]);
            tick();
        end
        on_off_i = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s3_valid_rel", valid_o, 1);
            chk("s3_data_rel", data_o, f3[k]);
            tick();
        end
        @(negedge clk); chk("s3_vc1_free", vc_free_o[1], 1);
        tick();

        // Re-occupy VC1/VC2, then free VC0 with a TAIL while requesting
        alloc_req_i = 1'b1;
        @(negedge clk); chk("s4_grant1", alloc_vc_o, 1);
        tick();
        @(negedge clk); chk("s4_grant2", alloc_vc_o, 2);
        tick();
        alloc_req_i = 1'b0;
        fh = mk(HEAD, 0); ft = mk(TAIL, 0);
        data_i = fh; valid_i = 1'b1;
        tick();
        data_i = ft;
        tick();
        valid_i = 1'b0; alloc_req_i = 1'b1;
        @(negedge clk);
        chk("s4_tail_sent", data_o, ft);
        chk("s4_tail_valid", valid_o, 1);
        chk("s4_no_grant_same", alloc_valid_o, 0);
        tick();
        @(negedge clk);
        chk("s4_grant_next", alloc_valid_o, 1);
        chk("s4_grant_vc0", alloc_vc_o, 0);
        tick();
        alloc_req_i = 1'b0;

        // Reset with two flits buffered on stalled VC3
        on_off_i = 4'b0111;
        fh = mk(HEAD, 3); fb = mk(BODY, 3);
        data_i = fh; valid_i = 1'b1;
        tick();
        data_i = fb;
        tick();
        valid_i = 1'b0;
        @(negedge clk); chk("s5_held", data_o, fh); chk("s5_stalled", valid_o, 0);
        tick();
        on_off_i = '1;
        rst = 1'b0;
        #1;
        chk("s5_rst_valid", valid_o, 0);
        chk("s5_rst_data", data_o, 0);
        chk("s5_rst_free", vc_free_o, 4'hf);
        tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("s5_no_partial", valid_o, 0);
            tick();
        end

        // BODY on FREE VC3
        data_i = mk(BODY, 3); valid_i = 1'b1;
        @(negedge clk); chk("s6_err_before", error_o, 0);
        tick();
        valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("s6_err_sticky", error_o, exp_err);
            tick();
        end
        rst = 1'b0;
        #1; chk("s6_err_rst", error_o, 0);
        tick();
        rst = 1'b1;
        tick();

        // Random legal packets with random on/off back-pressure
        for (int p = 0; p < 30; p++) begin
            alloc_req_i = 1'b1;
            got = 1'b0;
            vc  = 0;
            for (int t = 0; t < 60; t++) begin
                @(negedge clk);
                if (alloc_valid_o) begin
                    got = 1'b1;
                    vc  = alloc_vc_o;
                end
                tick();
                on_off_i = 4'($urandom) | 4'($urandom);
                if (got) break;
            end
            alloc_req_i = 1'b0;
            chk("rand_grant", got, 1);
            if (got) begin
                len = $urandom_range(2, 5);
                for (int k = 0; k < len; k++) begin
                    repeat ($urandom_range(0, 1)) begin
                        tick();
                        on_off_i = 4'($urandom) | 4'($urandom);
                    end
                    send_flit(mk((k == 0) ? HEAD : ((k == len - 1) ? TAIL : BODY), vc));
                end
            end
        end

        on_off_i = '1;
        for (int t = 0; t < 50; t++) begin
            tick();
            if (exp_q.size() == 0) break;
        end
        tick();
        chk("drain", exp_q.size(), 0);
        chk("all_free_end", vc_free_o, 4'hf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/output_port_tx.md
OUTPUT_PORT_TX -- requirements
Module: output_port_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: entries of the internal transmit FIFO; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 data_i  input  flit_t  flit from crossbar; vc_id holds the downstream VC.
REQ-005 valid_i  input  1  data_i valid.
REQ-006 ready_o  output  1  FIFO can accept; a transfer occurs when valid_i and ready_o are both high.
REQ-007 on_off_i  input  VC_NUM  per-downstream-VC on/off flow control from the downstream input buffers.
REQ-008 alloc_req_i  input  1  VC allocation request for a new packet.
REQ-009 alloc_valid_o  output  1  grant issued this cycle.
REQ-010 alloc_vc_o  output  VC_SIZE  granted downstream VC.
REQ-011 data_o  output  flit_t  flit on link.
REQ-012 valid_o  output  1  data_o is transmitted this cycle.
REQ-013 vc_free_o  output  VC_NUM  per-VC FREE status.
REQ-014 error_o  output  1  sticky protocol-error flag.

Function
REQ-015 The block SHALL hold a per-VC two-state FSM: FREE -> BUSY on grant; BUSY -> FREE on transmit of a TAIL flit with that vc_id.
- Both transitions take effect on the next edge.
REQ-016 Allocation SHALL be combinational when alloc_req_i is high and at least one VC is FREE.
- Grant the first FREE VC at or after rr_ptr, wrapping modulo VC_NUM.
- alloc_valid_o=1; alloc_vc_o=that VC.
- rr_ptr advances to granted+1 (wrap) on the next edge.
REQ-017 With no FREE VC, alloc_valid_o SHALL be 0 and alloc_vc_o 0; rr_ptr is unchanged.
REQ-018 A VC freed by a TAIL in cycle N SHALL NOT be grantable before cycle N+1.
REQ-019 Accepted flits SHALL enter the FIFO in order; ready_o=0 only when the FIFO holds FIFO_DEPTH entries.
REQ-020 The head FIFO entry SHALL be loaded into the output register whenever the register is empty or its flit is transmitting that cycle.
REQ-021 valid_o SHALL equal output-register-valid AND on_off_i[data_o.vc_id]; the flit leaves in any cycle valid_o is high.
REQ-022 Minimum latency SHALL be one cycle: a flit accepted in cycle N with FIFO empty and on_off high is on data_o with valid_o=1 in cycle N+1.
REQ-023 While on_off_i[vc] is low, the output flit SHALL hold stable and the FIFO SHALL fill, then deassert ready_o; no flit is dropped.
REQ-024 Simultaneous FIFO push and pop SHALL be allowed when full, keeping occupancy constant.
REQ-025 data_o SHALL be 0 whenever the output register is empty.

Reset
REQ-026 While rst is low, outputs and state SHALL be cleared asynchronously:
- all VCs FREE (vc_free_o all 1), rr_ptr 0;
- FIFO empty, output register empty;
- valid_o 0, data_o 0, alloc_valid_o 0, error_o 0.
REQ-027 Reset asserted mid-packet SHALL discard all buffered flits with no partial transmission after release.
REQ-028 ready_o SHALL be 1 from the first edge after reset release.

Configuration
REQ-029 With OUTPUT_PORT_TX_CHECK_EN defined, error_o SHALL set on the next edge and stay set until reset when any of these occurs:
- a flit is accepted whose vc_id is FREE;
- a HEAD is accepted on a VC with an open packet.
REQ-030 Without OUTPUT_PORT_TX_CHECK_EN, error_o SHALL be constant 0 and no check logic is synthesized.

Structure
REQ-031 flit_t, flit_label_t, VC_NUM and VC_SIZE SHALL come from noc_params; a new tx_vc_state_t enum (FREE, BUSY) SHALL be added there.
REQ-032 The FIFO SHALL be a sub-module named tx_fifo, parameterized by FIFO_DEPTH, with push/pop/full/empty.

Verification
REQ-033 The bench SHALL cover these scenarios:
- Reset release, then alloc_req_i=1 for 4 cycles with VC_NUM=4 -> grants VC 0,1,2,3; fifth request -> alloc_valid_o=0.
- HEAD/BODY/TAIL on VC2 with on_off_i all 1 -> each appears one cycle after acceptance; vc_free_o[2]=1 the cycle after TAIL.
- on_off_i[1]=0 with 3 flits on VC1, FIFO_DEPTH=2 -> data_o held, ready_o=0 after the FIFO fills; on_off_i[1]=1 -> flits delivered in order.
- TAIL on VC0 sent in cycle N while alloc_req_i=1 and only VC0 busy-freeing -> no grant in N; grant of VC0 in N+1.
- Reset pulled low while 2 flits are buffered -> valid_o=0 immediately; vc_free_o all 1.
- With OUTPUT_PORT_TX_CHECK_EN: BODY on FREE VC3 -> error_o=1 next cycle and held until reset.
